// File: rtl/mem_bridge_pkg.sv
// Shared types and bus polarity constants for the main-memory bridge sequencer.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_DRIVE  = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5
  } state_e;

  localparam logic LOAD_ACTIVE = 1'b0;
  localparam logic DIR_READ    = 1'b1;
  localparam logic DIR_WRITE   = 1'b0;

  localparam logic [15:0] ROM_TOP_DEFAULT = 16'h7FFF;

endpackage

// File: rtl/mem_bridge_sequencer.sv
// Single-beat load/store sequencer for the 64K shadow memory bus with
// read/write turnaround, wait states and optional ROM write protection.
module mem_bridge_sequencer
  import mem_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES       = 0,
  parameter logic [15:0] ROM_TOP           = ROM_TOP_DEFAULT,
  parameter bit          ROM_WRITE_PROTECT = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [15:0] Req_Addr,
  input  logic [7:0]  Req_WData,
  output logic        Rsp_Valid,
  output logic [7:0]  Rsp_RData,
  output logic        Rsp_Err,
  output logic [15:0] Addr,
  inout  wire  [7:0]  MEMDATA,
  output logic        MemBridge_Load,
  output logic        MemBridge_Direction,
  output logic        Memory_Ack,
  input  logic        DebugMemoryErrorWeirdness,
  input  logic        Err_Clear,
  output logic        Err_Sticky
);

  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  state_e      state, state_d;
  logic [3:0]  wcnt, wcnt_d;
  logic [15:0] addr_d;
  logic [7:0]  wdata_q, wdata_d, rdata_d;
  logic        oe_q, oe_d;
  logic        load_d, dir_d, ack_d, rsp_valid_d, rsp_err_d;
  logic        accept, wr_protected;

  assign Req_Ready    = (state == IDLE);
  assign accept       = Req_Valid && Req_Ready;
  assign wr_protected = ROM_WRITE_PROTECT && (Req_Addr <= ROM_TOP);

  // Bridge drives the bus only from registered enable; released one cycle
  // before the memory may be enabled again.
  assign MEMDATA = oe_q ? wdata_q : 8'hzz;

  // Next-state and next-value logic; every bus output is then registered.
  always_comb begin
    state_d     = state;
    wcnt_d      = wcnt;
    addr_d      = Addr;
    wdata_d     = wdata_q;
    rdata_d     = Rsp_RData;
    oe_d        = oe_q;
    load_d      = MemBridge_Load;
    dir_d       = MemBridge_Direction;
    ack_d       = Memory_Ack;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!Req_Write) begin
            addr_d  = Req_Addr;
            dir_d   = DIR_READ;
            state_d = RD_SETUP;
          end else if (wr_protected) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            addr_d  = Req_Addr;
            wdata_d = Req_WData;
            dir_d   = DIR_WRITE;
            oe_d    = 1'b1;
            state_d = WR_SETUP;
          end
        end
      end
      RD_SETUP: begin
        ack_d   = 1'b1;
        wcnt_d  = WS4;
        state_d = RD_DRIVE;
      end
      RD_DRIVE: begin
        if (wcnt == 4'd0) begin
          rdata_d     = MEMDATA;
          rsp_valid_d = 1'b1;
          ack_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          wcnt_d = wcnt - 4'd1;
        end
      end
      WR_SETUP: begin
        load_d  = LOAD_ACTIVE;
        wcnt_d  = WS4;
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        if (wcnt == 4'd0) begin
          load_d  = ~LOAD_ACTIVE;
          state_d = WR_HOLD;
        end else begin
          wcnt_d = wcnt - 4'd1;
        end
      end
      WR_HOLD: begin
        oe_d        = 1'b0;
        dir_d       = DIR_READ;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state               <= IDLE;
      wcnt                <= 4'd0;
      Addr                <= 16'h0000;
      wdata_q             <= 8'h00;
      oe_q                <= 1'b0;
      MemBridge_Load      <= ~LOAD_ACTIVE;
      MemBridge_Direction <= DIR_READ;
      Memory_Ack          <= 1'b0;
      Rsp_Valid           <= 1'b0;
      Rsp_RData           <= 8'h00;
      Rsp_Err             <= 1'b0;
    end else begin
      state               <= state_d;
      wcnt                <= wcnt_d;
      Addr                <= addr_d;
      wdata_q             <= wdata_d;
      oe_q                <= oe_d;
      MemBridge_Load      <= load_d;
      MemBridge_Direction <= dir_d;
      Memory_Ack          <= ack_d;
      Rsp_Valid           <= rsp_valid_d;
      Rsp_RData           <= rdata_d;
      Rsp_Err             <= rsp_err_d;
    end
  end

  // Set has priority over clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                          Err_Sticky <= 1'b0;
    else if (DebugMemoryErrorWeirdness) Err_Sticky <= 1'b1;
    else if (Err_Clear)                 Err_Sticky <= 1'b0;
  end

endmodule
